mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage LoongArch pipeline, between EX and WB. Holds one instruction,

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX -> MS handshake and payload bundle. EX drives the instruction
// fields and es_to_ms_valid; MS answers with ms_allowin.
interface mem_stage_if #(
  parameter int EX_W = 81
);
  logic            es_to_ms_valid;
  logic            ms_allowin;
  logic [31:0]     es_pc;
  logic [31:0]     es_res;
  logic [4:0]      es_rf_waddr;
  logic            es_rf_we;
  logic            es_res_from_mem;
  logic [4:0]      es_ld_op;
  logic            es_mem_req;
  logic            es_csr_re;
  logic [EX_W-1:0] es_ex_zip;

  modport master (
    output es_to_ms_valid, es_pc, es_res, es_rf_waddr, es_rf_we,
           es_res_from_mem, es_ld_op, es_mem_req, es_csr_re, es_ex_zip,
    input  ms_allowin
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_res, es_rf_waddr, es_rf_we,
           es_res_from_mem, es_ld_op, es_mem_req, es_csr_re, es_ex_zip,
    output ms_allowin
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage LoongArch pipeline (EX -> MS -> WB).
// Holds one instruction, waits for the data-SRAM response of a load/store
// issued in EX, aligns and extends load data, and hands the result to WB.
// A response that arrives while WB is stalled is parked in rdata_buf, and
// the response belonging to a flushed instruction is swallowed via discard.
module mem_stage #(
  parameter int EX_W = 81
) (
  input  logic            clk,
  input  logic            resetn,
  mem_stage_if.slave      es_bus,
  input  logic            data_sram_data_ok,
  input  logic [31:0]     data_sram_rdata,
  input  logic            ws_allowin,
  input  logic            wb_ex,
  input  logic            ertn_flush,
  output logic            ms_to_ws_valid,
  output logic [31:0]     ms_pc,
  output logic [31:0]     ms_rf_wdata,
  output logic [4:0]      ms_rf_waddr,
  output logic            ms_rf_we,
  output logic            ms_csr_re,
  output logic [EX_W-1:0] ms_ex_zip,
  output logic            ms_fwd_we,
  output logic [4:0]      ms_fwd_waddr,
  output logic [31:0]     ms_fwd_wdata,
  output logic            ms_fwd_blk,
  output logic            ms_ex_to_es
);

  logic        ms_valid;
  logic [31:0] ms_res;
  logic        ms_res_from_mem;
  logic [4:0]  ms_ld_op;
  logic        ms_mem_req;
  logic [31:0] rdata_buf;
  logic        buf_valid;
  logic        discard;

  logic        flush;
  logic        data_ok_eff;
  logic        wait_data;
  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_leave;
  logic        ms_load;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] ld_data;

  // Handshake: a strobe owed to a flushed instruction never satisfies the wait.
  always_comb begin
    flush          = wb_ex | ertn_flush;
    data_ok_eff    = data_sram_data_ok & ~discard;
    wait_data      = ms_valid & ms_mem_req & ~buf_valid;
    ms_ready_go    = ~wait_data | data_ok_eff;
    ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid & ms_ready_go;
    ms_leave       = ms_to_ws_valid & ws_allowin;
    ms_load        = es_bus.es_to_ms_valid & ms_allowin & ~flush;
  end

  assign es_bus.ms_allowin = ms_allowin;

  // Load alignment: pick byte/half by address offset, then sign or zero extend
  // according to the one-hot load type {ld.hu,ld.bu,ld.w,ld.h,ld.b}.
  always_comb begin
    load_word = buf_valid ? rdata_buf : data_sram_rdata;
    case (ms_res[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = ms_res[1] ? load_word[31:16] : load_word[15:0];
    ld_data = ({32{ms_ld_op[0]}} & {{24{load_byte[7]}}, load_byte})
            | ({32{ms_ld_op[1]}} & {{16{load_half[15]}}, load_half})
            | ({32{ms_ld_op[2]}} & load_word)
            | ({32{ms_ld_op[3]}} & {24'd0, load_byte})
            | ({32{ms_ld_op[4]}} & {16'd0, load_half});
    ms_rf_wdata = ms_res_from_mem ? ld_data : ms_res;
  end

  // Bypass/stall info for ID and exception-pending flag for EX.
  always_comb begin
    ms_fwd_we    = ms_valid & ms_rf_we;
    ms_fwd_waddr = ms_rf_waddr;
    ms_fwd_wdata = ms_rf_wdata;
    ms_fwd_blk   = ms_valid & ms_rf_we & ((ms_res_from_mem & ~ms_ready_go) | ms_csr_re);
    ms_ex_to_es  = ms_valid & (ms_ex_zip[1] | ms_ex_zip[0]);
  end

  // Stage occupancy: flush wins, otherwise refill whenever the slot frees up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_bus.es_to_ms_valid;
    end
  end

  // Payload capture from EX, held while the instruction sits in MS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_pc           <= 32'd0;
      ms_res          <= 32'd0;
      ms_rf_waddr     <= 5'd0;
      ms_rf_we        <= 1'b0;
      ms_res_from_mem <= 1'b0;
      ms_ld_op        <= 5'd0;
      ms_mem_req      <= 1'b0;
      ms_csr_re       <= 1'b0;
      ms_ex_zip       <= '0;
    end else if (ms_load) begin
      ms_pc           <= es_bus.es_pc;
      ms_res          <= es_bus.es_res;
      ms_rf_waddr     <= es_bus.es_rf_waddr;
      ms_rf_we        <= es_bus.es_rf_we;
      ms_res_from_mem <= es_bus.es_res_from_mem;
      ms_ld_op        <= es_bus.es_ld_op;
      ms_mem_req      <= es_bus.es_mem_req;
      ms_csr_re       <= es_bus.es_csr_re;
      ms_ex_zip       <= es_bus.es_ex_zip;
    end
  end

  // Park response data that arrives while WB cannot take the instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf <= 32'd0;
      buf_valid <= 1'b0;
    end else if (flush || ms_leave) begin
      buf_valid <= 1'b0;
    end else if (wait_data && data_ok_eff && !ws_allowin) begin
      rdata_buf <= data_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  // Remember that a flushed load still has a response in flight; setting
  // takes priority so a flush during a discarded strobe re-arms for the
  // newer outstanding request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard <= 1'b0;
    end else if (flush && wait_data && !data_ok_eff) begin
      discard <= 1'b1;
    end else if (data_sram_data_ok && discard) begin
      discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each scenario pushes the WB-side result it
// expects when it drives EX, and pops/compares when MS hands off to WB.
module tb_mem_stage;
  localparam int EX_W = 81;

  logic            clk = 1'b0;
  logic            resetn;
  logic            data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            ws_allowin;
  logic            wb_ex;
  logic            ertn_flush;
  logic            ms_to_ws_valid;
  logic [31:0]     ms_pc;
  logic [31:0]     ms_rf_wdata;
  logic [4:0]      ms_rf_waddr;
  logic            ms_rf_we;
  logic            ms_csr_re;
  logic [EX_W-1:0] ms_ex_zip;
  logic            ms_fwd_we;
  logic [4:0]      ms_fwd_waddr;
  logic [31:0]     ms_fwd_wdata;
  logic            ms_fwd_blk;
  logic            ms_ex_to_es;

  mem_stage_if #(.EX_W(EX_W)) es_bus();

  mem_stage #(.EX_W(EX_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_bus            (es_bus.slave),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_we          (ms_rf_we),
    .ms_csr_re         (ms_csr_re),
    .ms_ex_zip         (ms_ex_zip),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_waddr      (ms_fwd_waddr),
    .ms_fwd_wdata      (ms_fwd_wdata),
    .ms_fwd_blk        (ms_fwd_blk),
    .ms_ex_to_es       (ms_ex_to_es)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        we;
    logic        csr_re;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Drive one instruction from EX for a single cycle; returns at posedge+1
  // with the instruction resident in MS.
  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] waddr,
                       input logic we, input logic from_mem, input logic [4:0] ld,
                       input logic req, input logic csr, input logic [EX_W-1:0] zip);
    es_bus.es_pc           = pc;
    es_bus.es_res          = res;
    es_bus.es_rf_waddr     = waddr;
    es_bus.es_rf_we        = we;
    es_bus.es_res_from_mem = from_mem;
    es_bus.es_ld_op        = ld;
    es_bus.es_mem_req      = req;
    es_bus.es_csr_re       = csr;
    es_bus.es_ex_zip       = zip;
    es_bus.es_to_ms_valid  = 1'b1;
    @(posedge clk);
    #1;
    es_bus.es_to_ms_valid  = 1'b0;
  endtask

  // Bounded wait for an MS->WB handoff; stops on the negedge where it is seen.
  task automatic wait_out(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ms_to_ws_valid, ms_fwd_we, ms_fwd_blk, ms_ex_to_es, ms_rf_we, ms_csr_re} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {ms_to_ws_valid, ms_fwd_we, ms_fwd_blk, ms_ex_to_es, ms_rf_we, ms_csr_re});
    else passed++;
    total++;
    if ({ms_pc, ms_rf_wdata, ms_rf_waddr, ms_fwd_waddr, ms_fwd_wdata} !== 106'd0)
      $display("[TB] FAIL reset_data: got pc=%h wdata=%h expected all zero", ms_pc, ms_rf_wdata);
    else passed++;
    total++;
    if (ms_ex_zip !== '0) $display("[TB] FAIL reset_zip: got %h expected 0", ms_ex_zip);
    else passed++;
    total++;
    if (es_bus.ms_allowin !== 1'b1)
      $display("[TB] FAIL reset_allowin: got %b expected 1", es_bus.ms_allowin);
    else passed++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    bit ok; int n; exp_t e, g;
    ws_allowin = 1'b1;
    sb.push_back(exp_t'{pc: 32'h1c00_0000, wdata: 32'h0000_1234, waddr: 5'd4, we: 1'b1, csr_re: 1'b0});
    issue(32'h1c00_0000, 32'h0000_1234, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0);
    wait_out(4, ok, n);
    total++;
    if (!ok) $display("[TB] FAIL alu_out: no handoff within budget");
    else begin
      e = sb.pop_front();
      g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
      if (g !== e) $display("[TB] FAIL alu_out: got %h expected %h", g, e);
      else passed++;
    end
    total++;
    if (n !== 0) $display("[TB] FAIL alu_latency: got %0d extra cycles expected 0", n);
    else passed++;
    total++;
    if ({ms_fwd_we, ms_fwd_blk, ms_fwd_waddr, ms_fwd_wdata} !== {1'b1, 1'b0, 5'd4, 32'h0000_1234})
      $display("[TB] FAIL alu_fwd: got we=%b blk=%b addr=%0d data=%h expected 1 0 4 00001234",
               ms_fwd_we, ms_fwd_blk, ms_fwd_waddr, ms_fwd_wdata);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_byte();
    bit ok; int n; exp_t e, g;
    sb.push_back(exp_t'{pc: 32'h1c00_0004, wdata: 32'hFFFF_FF80, waddr: 5'd6, we: 1'b1, csr_re: 1'b0});
    issue(32'h1c00_0004, 32'h1000_0003, 5'd6, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({ms_fwd_blk, ms_to_ws_valid} !== 2'b10)
        $display("[TB] FAIL ldb_wait_blk: got blk=%b valid=%b expected blk=1 valid=0",
                 ms_fwd_blk, ms_to_ws_valid);
      else passed++;
      @(posedge clk);
      #1;
    end
    data_sram_rdata   = 32'h80FF_0011;
    data_sram_data_ok = 1'b1;
    wait_out(1, ok, n);
    total++;
    if (!ok) $display("[TB] FAIL ldb_out: no handoff on data_ok");
    else begin
      e = sb.pop_front();
      g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
      if (g !== e) $display("[TB] FAIL ldb_out: got %h expected %h", g, e);
      else passed++;
    end
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_load_half();
    bit ok; int n; exp_t e, g;
    logic [4:0]  ld;
    logic [31:0] want;
    for (int k = 0; k < 2; k++) begin
      ld   = (k == 0) ? 5'b10000 : 5'b00010;
      want = (k == 0) ? 32'h0000_8001 : 32'hFFFF_8001;
      sb.push_back(exp_t'{pc: 32'h1c00_0008 + 32'(k * 4), wdata: want, waddr: 5'd7, we: 1'b1, csr_re: 1'b0});
      issue(32'h1c00_0008 + 32'(k * 4), 32'h0000_2002, 5'd7, 1'b1, 1'b1, ld, 1'b1, 1'b0, '0);
      data_sram_rdata   = 32'h8001_FFFF;
      data_sram_data_ok = 1'b1;
      wait_out(1, ok, n);
      total++;
      if (!ok) $display("[TB] FAIL ldh_out[%0d]: no handoff on data_ok", k);
      else begin
        e = sb.pop_front();
        g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
        if (g !== e) $display("[TB] FAIL ldh_out[%0d]: got %h expected %h", k, g, e);
        else passed++;
      end
      @(posedge clk);
      #1;
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int n; exp_t e, g;
    sb.push_back(exp_t'{pc: 32'h1c00_0100, wdata: 32'hA5A5_0001, waddr: 5'd10, we: 1'b1, csr_re: 1'b0});
    sb.push_back(exp_t'{pc: 32'h1c00_0104, wdata: 32'h5A5A_0002, waddr: 5'd11, we: 1'b0, csr_re: 1'b0});
    es_bus.es_pc = 32'h1c00_0100; es_bus.es_res = 32'hA5A5_0001; es_bus.es_rf_waddr = 5'd10;
    es_bus.es_rf_we = 1'b1; es_bus.es_res_from_mem = 1'b0; es_bus.es_ld_op = 5'd0;
    es_bus.es_mem_req = 1'b0; es_bus.es_csr_re = 1'b0; es_bus.es_ex_zip = '0;
    es_bus.es_to_ms_valid = 1'b1;
    @(posedge clk);
    #1;
    es_bus.es_pc = 32'h1c00_0104; es_bus.es_res = 32'h5A5A_0002; es_bus.es_rf_waddr = 5'd11;
    es_bus.es_rf_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_out(1, ok, n);
      total++;
      if (!ok) $display("[TB] FAIL b2b_out[%0d]: no handoff in consecutive cycle", k);
      else begin
        e = sb.pop_front();
        g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
        if (g !== e) $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", k, g, e);
        else passed++;
      end
      @(posedge clk);
      #1;
      es_bus.es_to_ms_valid = 1'b0;
    end
  endtask

  task automatic test_buffer();
    bit ok; int n; exp_t e, g;
    ws_allowin = 1'b0;
    sb.push_back(exp_t'{pc: 32'h1c00_0200, wdata: 32'hDEAD_BEEF, waddr: 5'd12, we: 1'b1, csr_re: 1'b0});
    issue(32'h1c00_0200, 32'h0000_3000, 5'd12, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, '0);
    data_sram_rdata   = 32'hDEAD_BEEF;
    data_sram_data_ok = 1'b1;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1234_5678;
    @(negedge clk);
    total++;
    if ({dut.buf_valid, ms_to_ws_valid, ms_fwd_blk} !== 3'b110)
      $display("[TB] FAIL buf_capture: got buf=%b valid=%b blk=%b expected 1 1 0",
               dut.buf_valid, ms_to_ws_valid, ms_fwd_blk);
    else passed++;
    @(posedge clk);
    #1;
    ws_allowin = 1'b1;
    wait_out(1, ok, n);
    total++;
    if (!ok) $display("[TB] FAIL buf_out: no handoff after ws_allowin");
    else begin
      e = sb.pop_front();
      g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
      if (g !== e) $display("[TB] FAIL buf_out: got %h expected %h", g, e);
      else passed++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({dut.buf_valid, ms_to_ws_valid} !== 2'b00)
      $display("[TB] FAIL buf_clear: got buf=%b valid=%b expected 0 0", dut.buf_valid, ms_to_ws_valid);
    else passed++;
  endtask

  task automatic test_flush_discard();
    bit ok; int n; exp_t e, g;
    issue(32'h1c00_0300, 32'h0000_4000, 5'd13, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, '0);
    wb_ex = 1'b1;
    @(posedge clk);
    #1;
    wb_ex = 1'b0;
    @(negedge clk);
    total++;
    if ({ms_to_ws_valid, dut.discard} !== 2'b01)
      $display("[TB] FAIL flush_state: got valid=%b discard=%b expected 0 1", ms_to_ws_valid, dut.discard);
    else passed++;
    sb.push_back(exp_t'{pc: 32'h1c00_0304, wdata: 32'h5555_1234, waddr: 5'd14, we: 1'b1, csr_re: 1'b0});
    issue(32'h1c00_0304, 32'h0000_5000, 5'd14, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, '0);
    data_sram_rdata   = 32'hAAAA_AAAA;
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    total++;
    if ({ms_to_ws_valid, ms_fwd_blk} !== 2'b01)
      $display("[TB] FAIL stale_strobe: got valid=%b blk=%b expected 0 1", ms_to_ws_valid, ms_fwd_blk);
    else passed++;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if ({ms_to_ws_valid, dut.discard, dut.buf_valid} !== 3'b000)
      $display("[TB] FAIL discard_clear: got valid=%b discard=%b buf=%b expected 0 0 0",
               ms_to_ws_valid, dut.discard, dut.buf_valid);
    else passed++;
    @(posedge clk);
    #1;
    data_sram_rdata   = 32'h5555_1234;
    data_sram_data_ok = 1'b1;
    wait_out(1, ok, n);
    total++;
    if (!ok) $display("[TB] FAIL flush_out: no handoff on second data_ok");
    else begin
      e = sb.pop_front();
      g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
      if (g !== e) $display("[TB] FAIL flush_out: got %h expected %h", g, e);
      else passed++;
    end
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_zip();
    bit ok; int n; exp_t e, g;
    logic [EX_W-1:0] zip;
    zip = {1'b1, 32'hFFFF_0000, 32'h1234_5678, 14'h0006, 1'b1, 1'b0};
    sb.push_back(exp_t'{pc: 32'h1c00_0400, wdata: 32'h0000_0077, waddr: 5'd15, we: 1'b1, csr_re: 1'b1});
    issue(32'h1c00_0400, 32'h0000_0077, 5'd15, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, zip);
    wait_out(2, ok, n);
    total++;
    if (!ok) $display("[TB] FAIL zip_out: no handoff within budget");
    else begin
      e = sb.pop_front();
      g = {ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we, ms_csr_re};
      if (g !== e) $display("[TB] FAIL zip_out: got %h expected %h", g, e);
      else passed++;
    end
    total++;
    if (ms_ex_zip !== zip) $display("[TB] FAIL zip_value: got %h expected %h", ms_ex_zip, zip);
    else passed++;
    total++;
    if ({ms_ex_to_es, ms_fwd_blk} !== 2'b11)
      $display("[TB] FAIL zip_flags: got ex_to_es=%b blk=%b expected 1 1", ms_ex_to_es, ms_fwd_blk);
    else passed++;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (ms_ex_to_es !== 1'b0) $display("[TB] FAIL zip_drop: got ex_to_es=%b expected 0", ms_ex_to_es);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    issue(32'h1c00_0500, 32'h0000_6000, 5'd16, 1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, '0);
    @(negedge clk);
    total++;
    if (ms_fwd_blk !== 1'b1) $display("[TB] FAIL rst_pre_blk: got %b expected 1", ms_fwd_blk);
    else passed++;
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({ms_to_ws_valid, ms_fwd_we, ms_fwd_blk, ms_ex_to_es, ms_rf_we, ms_pc, ms_rf_wdata} !== 69'd0)
      $display("[TB] FAIL rst_mid_wait: got valid=%b fwd_we=%b blk=%b pc=%h wdata=%h expected all zero",
               ms_to_ws_valid, ms_fwd_we, ms_fwd_blk, ms_pc, ms_rf_wdata);
    else passed++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    total++;
    if ({ms_to_ws_valid, ms_fwd_we, dut.buf_valid} !== 3'b000)
      $display("[TB] FAIL rst_stray_ok: got valid=%b fwd_we=%b buf=%b expected 0 0 0",
               ms_to_ws_valid, ms_fwd_we, dut.buf_valid);
    else passed++;
    @(posedge clk);
    #1;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    resetn                = 1'b0;
    data_sram_data_ok     = 1'b0;
    data_sram_rdata       = 32'd0;
    ws_allowin            = 1'b0;
    wb_ex                 = 1'b0;
    ertn_flush            = 1'b0;
    es_bus.es_to_ms_valid = 1'b0;
    es_bus.es_pc          = 32'd0;
    es_bus.es_res         = 32'd0;
    es_bus.es_rf_waddr    = 5'd0;
    es_bus.es_rf_we       = 1'b0;
    es_bus.es_res_from_mem = 1'b0;
    es_bus.es_ld_op       = 5'd0;
    es_bus.es_mem_req     = 1'b0;
    es_bus.es_csr_re      = 1'b0;
    es_bus.es_ex_zip      = '0;

    test_reset();
    test_alu();
    test_load_byte();
    test_load_half();
    test_back_to_back();
    test_buffer();
    test_flush_discard();
    test_zip();
    test_reset_mid_wait();

    total++;
    if (sb.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
